iodelay_tap_ctrl: RTL and testbench
===================================

# iodelay_tap_ctrl

Sequencer for one LIFCL IOLOGIC dynamic input/output delay (DELAYA/DELAYB in dynamic mode). It takes tap-target or reload requests over a valid/ready handshake, then drives the primitive's LOADN/MOVE/DIRECTION pins with correctly spaced pulses. It keeps a shadow copy of the current tap and aborts on the primitive's CFLAG limit indication. It sits between fabric calibration logic (e.g. eye-scan or DQS training) and the IOLOGIC site.

## Interface
- TAP_W, 7, tap counter width
- MAX_TAP, 127, highest legal tap; requests above it are clamped
- DEFAULT_TAP, 0, tap value the primitive assumes after LOADN
- MOVE_W, 1, MOVE high time in cycles (≥1)
- MOVE_GAP, 4, idle cycles after each MOVE pulse or LOADN (≥1)
- LOAD_W, 2, LOADN low time in cycles (≥1)

Ports:
- clk  in  1  sole clock; all pins to the primitive are registered on it
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle and accepting
- req_load  in  1  1 = reload via LOADN (req_tap ignored); 0 = move to req_tap
- req_tap  in  TAP_W  target tap
- done  out  1  one-cycle pulse when a request completes
- err_limit  out  1  sticky flag: clamp or CFLAG abort; cleared by the next accepted request
- cur_tap  out  TAP_W  shadow tap value
- dly_loadn  out  1  to primitive LOADN (active low)
- dly_move  out  1  to primitive MOVE
- dly_direction  out  1  to primitive DIRECTION; 0 = increase delay, 1 = decrease
- dly_cflag  in  1  primitive CFLAG, synchronous to clk

## Operation
- States: INIT_LOAD, INIT_GAP, IDLE, LOAD, SETDIR, PULSE, GAP, DONE.
- Reset values:
  - State INIT_LOAD.
  - dly_loadn=1, dly_move=0, dly_direction=0.
  - cur_tap=DEFAULT_TAP, req_ready=0, done=0, err_limit=0.
- INIT after reset:
  - dly_loadn is low for LOAD_W cycles, then MOVE_GAP idle cycles, then IDLE.
  - No done pulse is issued.
  - This sequence guarantees the hardware tap matches cur_tap.
- IDLE:
  - req_ready=1.
  - A request is accepted on a cycle with req_valid & req_ready.
  - req_ready drops the following cycle and stays low until IDLE is re-entered.
- Load request:
  - LOAD drives dly_loadn=0 for LOAD_W cycles.
  - GAP follows for MOVE_GAP cycles, then DONE.
  - cur_tap←DEFAULT_TAP when LOADN deasserts.
- Move request:
  - target = min(req_tap, MAX_TAP); err_limit=1 if clamped.
  - target==cur_tap: go straight to DONE; no pin activity.
  - Otherwise SETDIR runs one cycle, driving dly_direction = (target<cur_tap).
  - Then loop PULSE (dly_move=1 for MOVE_W cycles) → GAP (MOVE_GAP cycles).
  - cur_tap ±1 on the last PULSE cycle.
  - Exit to DONE when cur_tap==target.
- dly_direction is held constant from SETDIR until DONE; it never changes while dly_move=1.
- CFLAG handling:
  - If dly_cflag=1 is sampled in any PULSE cycle, that step is not counted (cur_tap unchanged).
  - err_limit is set, and the state finishes the current GAP, then goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- dly_loadn and dly_move are never low and high, respectively, in the same cycle.
- Reset asserted mid-operation:
  - All outputs return immediately to their reset values.
  - INIT re-runs after deassertion.

## Timing
- Request accepted at cycle T (move, N = |target−cur_tap| > 0, defaults):
  - SETDIR at T+1.
  - Step k has PULSE at T+2+5k and GAP at T+3+5k..T+6+5k.
  - done at T+2+5N; req_ready high at T+3+5N.
- General step period: MOVE_W+MOVE_GAP cycles.
- N=0: done at T+1, req_ready at T+2.
- Load: dly_loadn low at T+1..T+LOAD_W; gap T+LOAD_W+1..T+LOAD_W+MOVE_GAP; done at T+LOAD_W+MOVE_GAP+1 (default T+7).
- INIT: first clock after rst_n rises starts LOADN; req_ready=1 at cycle 1+LOAD_W+MOVE_GAP (default cycle 7).
- All primitive pins are driven from flops; no combinational path from req_* to dly_*.

## Test plan
- Reset release:
  - dly_loadn low exactly cycles 1–2, req_ready rises at cycle 7.
  - No done pulse; cur_tap=0.
- Move 0→5 accepted at T:
  - dly_direction=0 from T+1.
  - 5 MOVE pulses at T+2, T+7, …, T+22.
  - done at T+27, cur_tap=5, err_limit=0.
- Move 5→2:
  - dly_direction=1.
  - 3 pulses, done at T+17, cur_tap=2.
- Request tap 2 while at 2: no MOVE/LOADN, done at T+1.
- req_tap=200 with MAX_TAP=127 from tap 125: 2 pulses, cur_tap=127, err_limit=1.
- CFLAG and reset:
  - From 10 toward 20, dly_cflag=1 during the 3rd pulse: 3 pulses total, cur_tap=12, err_limit=1, done at end of that gap.
  - Then a load request: dly_loadn low 2 cycles, cur_tap=0, err_limit=0.
  - rst_n asserted mid-move: dly_move=0 immediately, INIT re-runs.

Source files
------------

// File: rtl/iodelay_tap_ctrl_if.sv
// Request/status bundle between calibration logic and the
// IODELAY tap sequencer.
interface iodelay_tap_ctrl_if #(
    parameter int TAP_W = 7
);
    logic             req_valid;
    logic             req_ready;
    logic             req_load;
    logic [TAP_W-1:0] req_tap;
    logic             done;
    logic             err_limit;
    logic [TAP_W-1:0] cur_tap;

    modport master (
        output req_valid, req_load, req_tap,
        input  req_ready, done, err_limit, cur_tap
    );

    modport slave (
        input  req_valid, req_load, req_tap,
        output req_ready, done, err_limit, cur_tap
    );
endinterface

// File: rtl/iodelay_tap_ctrl.sv
// Sequencer for one dynamic IOLOGIC delay: LOADN reloads and
// MOVE/DIRECTION stepping toward a target, with a shadow tap.
module iodelay_tap_ctrl #(
    parameter int TAP_W       = 7,
    parameter int MAX_TAP     = 127,
    parameter int DEFAULT_TAP = 0,
    parameter int MOVE_W      = 1,
    parameter int MOVE_GAP    = 4,
    parameter int LOAD_W      = 2
) (
    input  logic clk,
    input  logic rst_n,
    iodelay_tap_ctrl_if.slave bus,
    output logic dly_loadn,
    output logic dly_move,
    output logic dly_direction,
    input  logic dly_cflag
);
    typedef enum logic [2:0] {
        S_INIT_LOAD,
        S_INIT_GAP,
        S_IDLE,
        S_LOAD,
        S_SETDIR,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [TAP_W-1:0] L_MAX = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] L_DEF = TAP_W'(DEFAULT_TAP);
    localparam logic [7:0]       L_LW  = 8'(LOAD_W);
    localparam logic [7:0]       L_MW  = 8'(MOVE_W);
    localparam logic [7:0]       L_GAP = 8'(MOVE_GAP);

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [TAP_W-1:0] r_cur;
    logic [TAP_W-1:0] r_target;
    logic             r_abort;
    logic             r_ready;
    logic             r_done;
    logic             r_err;
    logic             r_loadn;
    logic             r_move;
    logic             r_dir;

    logic             w_accept;
    logic             w_clamp;
    logic [TAP_W-1:0] w_tgt;
    logic             w_hit;

    assign w_accept = bus.req_valid & r_ready;
    assign w_clamp  = bus.req_tap > L_MAX;
    assign w_tgt    = w_clamp ? L_MAX : bus.req_tap;
    assign w_hit    = r_abort | dly_cflag;

    assign bus.req_ready = r_ready;
    assign bus.done      = r_done;
    assign bus.err_limit = r_err;
    assign bus.cur_tap   = r_cur;
    assign dly_loadn     = r_loadn;
    assign dly_move      = r_move;
    assign dly_direction = r_dir;

    // Control FSM; every primitive pin and status bit is a flop here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_INIT_LOAD;
            r_cnt    <= 8'd0;
            r_cur    <= L_DEF;
            r_target <= L_DEF;
            r_abort  <= 1'b0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_loadn  <= 1'b1;
            r_move   <= 1'b0;
            r_dir    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_INIT_LOAD, S_LOAD: begin
                    if (r_cnt == L_LW) begin
                        r_loadn <= 1'b1;
                        r_cur   <= L_DEF;
                        r_cnt   <= 8'd1;
                        r_state <= (r_state == S_LOAD) ?
                                   S_GAP : S_INIT_GAP;
                    end else begin
                        r_loadn <= 1'b0;
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                S_INIT_GAP: begin
                    if (r_cnt == L_GAP) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_abort <= 1'b0;
                        if (bus.req_load) begin
                            r_err    <= 1'b0;
                            r_target <= L_DEF;
                            r_loadn  <= 1'b0;
                            r_cnt    <= 8'd1;
                            r_state  <= S_LOAD;
                        end else begin
                            r_err    <= w_clamp;
                            r_target <= w_tgt;
                            if (w_tgt == r_cur) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_dir   <= w_tgt < r_cur;
                                r_state <= S_SETDIR;
                            end
                        end
                    end
                end
                S_SETDIR: begin
                    r_move  <= 1'b1;
                    r_cnt   <= 8'd1;
                    r_state <= S_PULSE;
                end
                S_PULSE: begin
                    if (dly_cflag) begin
                        r_err   <= 1'b1;
                        r_abort <= 1'b1;
                    end
                    if (r_cnt == L_MW) begin
                        r_move  <= 1'b0;
                        r_cnt   <= 8'd1;
                        r_state <= S_GAP;
                        if (!w_hit) begin
                            r_cur <= r_dir ? r_cur - TAP_W'(1)
                                           : r_cur + TAP_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt != L_GAP) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else if (r_abort || r_cur == r_target) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_move  <= 1'b1;
                        r_cnt   <= 8'd1;
                        r_state <= S_PULSE;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_INIT_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_iodelay_tap_ctrl.sv
// Self-checking bench for iodelay_tap_ctrl: directed vector table,
// reset/init sequences and randomized requests against a model.
module tb_iodelay_tap_ctrl;
    localparam int TW   = 8;
    localparam int MAXT = 127;
    localparam int DEF  = 0;
    localparam int MW   = 1;
    localparam int MG   = 4;
    localparam int LW   = 2;
    localparam int PER  = MW + MG;

    typedef struct {
        bit load;
        int tap;
        int cstep;
        int lat;
        int pulses;
        int tap_after;
        bit err;
        bit dir;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dly_loadn, dly_move, dly_direction;
    logic dly_cflag = 1'b0;

    int errors = 0;
    int checks = 0;

    iodelay_tap_ctrl_if #(.TAP_W(TW)) bus ();

    iodelay_tap_ctrl #(
        .TAP_W(TW), .MAX_TAP(MAXT), .DEFAULT_TAP(DEF),
        .MOVE_W(MW), .MOVE_GAP(MG), .LOAD_W(LW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .dly_loadn(dly_loadn),
        .dly_move(dly_move),
        .dly_direction(dly_direction),
        .dly_cflag(dly_cflag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Expected outcome of one request from tap 'cur', from the rules.
    function automatic vec_t model(input int cur, input bit ld,
                                   input int tap, input int cs);
        vec_t r;
        int tgt, n;
        r.load = ld; r.tap = tap; r.cstep = cs;
        if (ld) begin
            r.cstep = -1; r.lat = LW + MG + 1; r.pulses = 0;
            r.tap_after = DEF; r.err = 0; r.dir = 0;
        end else begin
            tgt = (tap > MAXT) ? MAXT : tap;
            r.err = tap > MAXT;
            n = (tgt > cur) ? tgt - cur : cur - tgt;
            r.dir = tgt < cur;
            if (cs >= 0 && cs < n) begin
                r.pulses = cs + 1;
                r.err = 1;
                r.tap_after = r.dir ? cur - cs : cur + cs;
            end else begin
                r.pulses = n;
                r.tap_after = tgt;
            end
            r.lat = (r.pulses == 0) ? 1 : 2 + PER * r.pulses;
        end
        return r;
    endfunction

    // Release reset and watch the power-on LOADN sequence.
    task automatic init_check();
        int lo = 0, first_lo = -1, first_rdy = -1, dn = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!dly_loadn) begin
                lo++;
                if (first_lo < 0) first_lo = k;
            end
            if (bus.req_ready && first_rdy < 0) first_rdy = k;
            if (bus.done) dn++;
        end
        chk("init_loadn_cycles", lo, LW);
        chk("init_loadn_start", first_lo, 1);
        chk("init_ready_cycle", first_rdy, 1 + LW + MG);
        chk("init_no_done", dn, 0);
        chk("init_cur_tap", int'(bus.cur_tap), DEF);
    endtask

    task automatic run_req(input vec_t v);
        int lat = -1, pulses = 0, lo = 0, ovl = 0, badt = 0, dbad = 0;
        bit acc = 0;
        logic d0 = 1'b0;
        logic pm = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_load = v.load;
        bus.req_tap = TW'(v.tap);
        for (int w = 0; w < 50 && !acc; w++) begin
            @(negedge clk);
            acc = bus.req_ready;
        end
        chk("accept", int'(acc), 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_tap = '0;
        if (!acc) return;
        for (int k = 1; k <= 1500; k++) begin
            @(negedge clk);
            dly_cflag = 1'b0;
            if (k == 1) begin
                chk("ready_drop", int'(bus.req_ready), 0);
                d0 = dly_direction;
            end
            if (!dly_loadn) lo++;
            if (!dly_loadn && dly_move) ovl++;
            if (dly_move && dly_direction !== d0) dbad++;
            if (dly_move && !pm) begin
                if (k != 2 + PER * pulses) badt++;
                if (pulses == v.cstep) dly_cflag = 1'b1;
                pulses++;
            end
            pm = dly_move;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        dly_cflag = 1'b0;
        chk("done_latency", lat, v.lat);
        chk("pulse_count", pulses, v.pulses);
        chk("pulse_timing", badt, 0);
        chk("loadn_cycles", lo, v.load ? LW : 0);
        chk("loadn_move_overlap", ovl, 0);
        if (v.pulses > 0) begin
            chk("direction", int'(d0), int'(v.dir));
            chk("direction_stable", dbad, 0);
        end
        chk("cur_tap", int'(bus.cur_tap), v.tap_after);
        chk("err_limit", int'(bus.err_limit), int'(v.err));
        @(negedge clk);
        chk("done_width", int'(bus.done), 0);
        chk("ready_back", int'(bus.req_ready), 1);
    endtask

    vec_t vecs[8];

    initial begin
        int mcur;
        int npul;
        bit ok;
        vec_t v;

        vecs[0] = '{0, 5, -1, 27, 5, 5, 0, 0};
        vecs[1] = '{0, 2, -1, 17, 3, 2, 0, 1};
        vecs[2] = '{0, 2, -1, 1, 0, 2, 0, 0};
        vecs[3] = '{0, 125, -1, 617, 123, 125, 0, 0};
        vecs[4] = '{0, 200, -1, 12, 2, 127, 1, 0};
        vecs[5] = '{0, 10, -1, 587, 117, 10, 0, 1};
        vecs[6] = '{0, 20, 2, 17, 3, 12, 1, 0};
        vecs[7] = '{1, 0, -1, 7, 0, 0, 0, 0};

        bus.req_valid = 1'b0;
        bus.req_load = 1'b0;
        bus.req_tap = '0;

        repeat (3) @(negedge clk);
        chk("rst_loadn", int'(dly_loadn), 1);
        chk("rst_move", int'(dly_move), 0);
        chk("rst_dir", int'(dly_direction), 0);
        chk("rst_ready", int'(bus.req_ready), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.err_limit), 0);
        chk("rst_cur_tap", int'(bus.cur_tap), DEF);

        init_check();

        foreach (vecs[i]) run_req(vecs[i]);

        // Reset in the middle of a move, after two steps were taken.
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_load = 1'b0;
        bus.req_tap = TW'(50);
        ok = 0;
        for (int w = 0; w < 50 && !ok; w++) begin
            @(negedge clk);
            ok = bus.req_ready;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        npul = 0;
        ok = 0;
        for (int w = 0; w < 100 && !ok; w++) begin
            @(negedge clk);
            if (dly_move) npul++;
            ok = (npul == 3);
        end
        chk("midrst_reached_pulse", int'(ok), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_move", int'(dly_move), 0);
        chk("midrst_loadn", int'(dly_loadn), 1);
        chk("midrst_ready", int'(bus.req_ready), 0);
        chk("midrst_cur_tap", int'(bus.cur_tap), DEF);
        chk("midrst_done", int'(bus.done), 0);
        init_check();

        mcur = DEF;
        for (int i = 0; i < 40; i++) begin
            bit ld;
            int tap, cs;
            ld = $urandom_range(0, 99) < 12;
            if ($urandom_range(0, 9) == 0) begin
                tap = $urandom_range(0, 255);
            end else begin
                tap = mcur + $urandom_range(0, 24) - 12;
                if (tap < 0) tap = 0;
                if (tap > 255) tap = 255;
            end
            cs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
            v = model(mcur, ld, tap, cs);
            run_req(v);
            mcur = v.tap_after;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
